evm_tally_core: RTL
===================

// Module: evm_tally_core
// PURPOSE
//  Parametrised N-candidate electronic-voting tally engine for the FPGA EVM.
//  Takes raw candidate push-buttons, a presiding-officer ballot arm, result-show and clear switches.
//  Accepts exactly one vote per arm, keeps saturating per-candidate counts, and on show scans
//  all counts to report winner and tie. Sits between the board buttons and the 7-seg/LED display logic.
// PARAMETERS
//  N_CAND   3  number of candidates/channels (2..16)
//  CNT_W    8  per-candidate count width, bits
//  IDX_W    4  candidate index width; must satisfy 2**IDX_W >= N_CAND
// PORTS
//  clk          in   1             system clock; all logic on posedge
//  reset        in   1             synchronous, active-low reset
//  btn          in   N_CAND        raw candidate buttons, async, active-high
//  ballot_arm   in   1             raw officer button; rising edge arms one vote
//  show         in   1             level; 1 = result mode, voting blocked
//  clear        in   1             level; clears counts, honoured only when show=0
//  armed        out  1             1 while a vote may be cast
//  vote_led     out  N_CAND        confirmation LED of accepted candidate
//  reject       out  1             1-cycle pulse on an invalid press attempt
//  counts       out  N_CAND*CNT_W  candidate i at [i*CNT_W +: CNT_W]; all-zero unless result_valid
//  sat          out  N_CAND        sticky: candidate count has saturated
//  win_onehot   out  N_CAND        winning candidate (lowest index on tie); 0 unless result_valid
//  tie          out  1             >=2 candidates share the maximum count; 0 unless result_valid
//  result_valid out  1             scan complete, result outputs stable
// BEHAVIOUR
//  - reset=0 at posedge: state IDLE; counts, sat, all outputs and synchronisers cleared to 0.
//  - Each btn bit and ballot_arm: 2-FF synchroniser, then rising-edge detect (1-cycle pulse).
//  - FSM states: IDLE, ARMED, HOLD, SCAN, RESULT.
//    IDLE  : ballot_arm edge & show=0 -> ARMED. armed=0.
//    ARMED : armed=1. Exactly one btn edge and no other synced btn high -> count[i]++ next cycle,
//            vote_led[i]=1, -> HOLD. Edge with any other btn high/edge -> reject pulse, stay ARMED.
//            Further ballot_arm edges ignored (no double arm).
//    HOLD  : vote_led[i] held until all synced btn low -> IDLE, vote_led=0. Presses here ignored.
//    SCAN  : idx 0..N_CAND-1, one count compared per cycle; max, winner idx, tie updated. -> RESULT.
//    RESULT: result_valid=1, counts/win/tie driven. show=0 -> IDLE, result outputs return to 0.
//  - show=1 from IDLE/ARMED/HOLD -> SCAN next cycle; pending arm is discarded (not restored).
//  - Latency show sampled -> result_valid: N_CAND+1 cycles. Accepted edge -> count visible internally: 1.
//  - Compare: strictly greater replaces winner; equal to current max sets tie; new strict max clears tie.
//    All-zero counts -> winner 0, tie=1 (N_CAND>=2).
//  - Saturation: count at 2**CNT_W-1 stays; accepted vote there sets sat[i] (sticky until reset/clear);
//    vote still acknowledged (vote_led, HOLD).
//  - clear=1 with show=0: counts and sat zeroed next cycle, FSM -> IDLE; clear during show ignored.
//    Clear has priority over a same-cycle vote.
//  - reset mid-scan or mid-vote: everything returns to reset values; no partial count.
// STRUCTURE
//  - evm_pkg: FSM state enum (3-bit encoding), clog2 function, IDX_W default derivation.
//  - One sub-module evm_btn_sync (2-FF sync + edge detect), instantiated N_CAND+1 times.
//  - Core: FSM, count array, sequential scan datapath in evm_tally_core.
// TESTING
//  1 Arm, press btn[1] 3 cycles, release; repeat x2 -> show: counts={0,2,0}, win_onehot=3'b010,
//    tie=0, result_valid exactly N_CAND+1 cycles after show.
//  2 Arm, press btn[0] and btn[2] same cycle -> reject pulse once, armed stays 1, no count change;
//    then btn[2] alone -> count2=1.
//  3 Press btn[0] without arming, and press again in HOLD -> no increment, no reject.
//  4 Votes 2/2/1 -> win_onehot=3'b001, tie=1; all zero -> win=3'b001, tie=1.
//  5 CNT_W=2: 5 votes for cand 0 -> count0=3, sat[0]=1; clear with show=0 -> count0=0, sat=0;
//    clear with show=1 -> no change.
//  6 reset=0 during SCAN and during HOLD -> next cycle all outputs 0, state IDLE, counts 0.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared types and elaboration helpers for the EVM tally core.
// Exports: state_t (3-bit FSM encoding), clog2(), idx_w(), IDX_W_DEF.
package evm_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_HOLD   = 3'd2,
    S_SCAN   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  localparam int IDX_W_DEF = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Index bits actually needed to address N entries (never 0).
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/evm_tally_core_if.sv
// Board-side bundle of the tally core: buttons/switches in, results out.
// master = board/display side, slave = tally core.
interface evm_tally_core_if
  import evm_pkg::*;
#(
  parameter int N_CAND = 3,
  parameter int CNT_W  = 8
);
  logic [N_CAND-1:0]       btn;
  logic                    ballot_arm;
  logic                    show;
  logic                    clear;
  logic                    armed;
  logic [N_CAND-1:0]       vote_led;
  logic                    reject;
  logic [N_CAND*CNT_W-1:0] counts;
  logic [N_CAND-1:0]       sat;
  logic [N_CAND-1:0]       win_onehot;
  logic                    tie;
  logic                    result_valid;

  modport master (
    output btn, ballot_arm, show, clear,
    input  armed, vote_led, reject, counts,
    input  sat, win_onehot, tie, result_valid
  );

  modport slave (
    input  btn, ballot_arm, show, clear,
    output armed, vote_led, reject, counts,
    output sat, win_onehot, tie, result_valid
  );
endinterface

// File: rtl/evm_btn_sync.sv
// 2-FF synchroniser plus rising-edge detector for one raw button.
// Ports: clk, reset (sync, active-low), din raw, sync level, rise pulse.
module evm_btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~s3;
endmodule

// File: rtl/evm_tally_core.sv
// N-candidate vote tally: arm/vote/hold FSM, saturating counts, serial
// max scan. Ports: clk, reset (sync, active-low), bus (slave modport).
module evm_tally_core
  import evm_pkg::*;
#(
  parameter int N_CAND = 3,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  evm_tally_core_if.slave      bus
);
  localparam int AW = idx_w(N_CAND);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(N_CAND - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t st, nxt;

  logic [N_CAND-1:0] b_lvl, b_rise;
  logic              a_rise;
  logic              a_lvl;

  logic [CNT_W-1:0]  cnt [N_CAND];
  logic [N_CAND-1:0] sat_q, led_q;
  logic              rej_q, rej_c;
  logic              accept, clr, res;

  logic [IDX_W-1:0]  idx, win;
  logic [CNT_W-1:0]  mx, cur;
  logic              tie_r;

  logic                    rv_q, tie_o;
  logic [N_CAND*CNT_W-1:0] cnt_o, flat;
  logic [N_CAND-1:0]       win_o;

  for (genvar g = 0; g < N_CAND; g++) begin : g_btn
    evm_btn_sync u_sync (
      .clk  (clk),
      .reset(reset),
      .din  (bus.btn[g]),
      .sync (b_lvl[g]),
      .rise (b_rise[g])
    );
  end

  evm_btn_sync u_arm (
    .clk  (clk),
    .reset(reset),
    .din  (bus.ballot_arm),
    .sync (a_lvl),
    .rise (a_rise)
  );

  always_comb begin
    nxt    = st;
    accept = 1'b0;
    rej_c  = 1'b0;
    clr    = bus.clear & ~bus.show;
    unique case (st)
      S_IDLE: begin
        if (bus.show)    nxt = S_SCAN;
        else if (a_rise) nxt = S_ARMED;
      end
      S_ARMED: begin
        if (bus.show) begin
          nxt = S_SCAN;
        end else if (|b_rise) begin
          // Accept only a lone press: any other
          // button held or rising voids it.
          if ($onehot(b_rise) &&
              ((b_lvl & ~b_rise) == '0)) begin
            accept = 1'b1;
            nxt    = S_HOLD;
          end else begin
            rej_c = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (bus.show)         nxt = S_SCAN;
        else if (b_lvl == '0) nxt = S_IDLE;
      end
      S_SCAN: begin
        if (idx == LAST) nxt = S_RESULT;
      end
      S_RESULT: begin
        if (!bus.show) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    if (clr) begin
      nxt    = S_IDLE;
      accept = 1'b0;
      rej_c  = 1'b0;
    end
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < N_CAND; i++)
      flat[i*CNT_W +: CNT_W] = cnt[i];
  end

  assign cur = cnt[idx[AW-1:0]];
  assign res = (st == S_RESULT) & bus.show;

  always_ff @(posedge clk) begin
    if (!reset) begin
      st    <= S_IDLE;
      cnt   <= '{default: '0};
      sat_q <= '0;
      led_q <= '0;
      rej_q <= 1'b0;
      idx   <= '0;
      win   <= '0;
      mx    <= '0;
      tie_r <= 1'b0;
      rv_q  <= 1'b0;
      cnt_o <= '0;
      win_o <= '0;
      tie_o <= 1'b0;
    end else begin
      st    <= nxt;
      rej_q <= rej_c;

      if (clr) begin
        cnt   <= '{default: '0};
        sat_q <= '0;
      end else if (accept) begin
        for (int i = 0; i < N_CAND; i++) begin
          if (b_rise[i]) begin
            if (cnt[i] == CMAX) sat_q[i] <= 1'b1;
            else cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end

      if (accept)            led_q <= b_rise;
      else if (nxt != S_HOLD) led_q <= '0;

      if (st != S_SCAN) begin
        idx <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
        if (idx == '0) begin
          mx    <= cur;
          win   <= '0;
          tie_r <= 1'b0;
        end else if (cur > mx) begin
          mx    <= cur;
          win   <= idx;
          tie_r <= 1'b0;
        end else if (cur == mx) begin
          tie_r <= 1'b1;
        end
      end

      // Result outputs are registered one cycle
      // behind RESULT and fall with show.
      rv_q  <= res;
      cnt_o <= res ? flat : '0;
      win_o <= res ? (N_CAND'(1) << win) : '0;
      tie_o <= res & tie_r;
    end
  end

  assign bus.armed        = (st == S_ARMED);
  assign bus.vote_led     = led_q;
  assign bus.reject       = rej_q;
  assign bus.counts       = cnt_o;
  assign bus.sat          = sat_q;
  assign bus.win_onehot   = win_o;
  assign bus.tie          = tie_o;
  assign bus.result_valid = rv_q;
endmodule
